// File: rtl/seq_sub_pkg.sv
// Shared definitions for the sequential subtractor: FSM encoding and
// elaboration-time helpers for the chunk count and counter width.
package seq_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_CHUNK = 8;

  function automatic int calc_ncyc(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 1;
  endfunction

  // A single-chunk configuration still needs a 1-bit counter.
  function automatic int calc_cnt_w(input int ncyc);
    return (ncyc <= 1) ? 1 : $clog2(ncyc);
  endfunction

endpackage

// File: rtl/seq_sub64_sub_chunk.sv
// CHUNK-bit ripple of full-adder cells; subtraction is done by the caller
// feeding the inverted subtrahend and an inverted borrow as carry-in.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module sub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] nb,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (nb[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/seq_sub64.sv
// Multi-cycle ripple-borrow subtractor: diff = a - b - bin, one CHUNK-bit
// slice per clock through a single sub_chunk, behind valid/ready handshakes.
//
//  state | meaning
//  IDLE  | waiting for operands, in_ready=1
//  RUN   | one chunk per cycle, carry held in carry_q
//  DONE  | result and flags presented until out_ready
module seq_sub64
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCYC = calc_ncyc(WIDTH, CHUNK);
  localparam int CW   = calc_cnt_w(NCYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("seq_sub64: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [CHUNK-1:0] a_chunk, nb_chunk, s_chunk;
  logic             c_chunk;

  assign a_chunk  = a_q[int'(cnt_q)*CHUNK +: CHUNK];
  assign nb_chunk = nb_q[int'(cnt_q)*CHUNK +: CHUNK];

  sub_chunk #(.CHUNK(CHUNK)) u_sub_chunk (
    .a    (a_chunk),
    .nb   (nb_chunk),
    .cin  (carry_q),
    .s    (s_chunk),
    .cout (c_chunk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      nb_q    <= '0;
      diff_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      diff_q  <= diff_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    nb_d    = nb_q;
    diff_d  = diff_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          nb_d    = ~b;
          carry_d = ~bin;
          diff_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[int'(cnt_q)*CHUNK +: CHUNK] = s_chunk;
        carry_d = c_chunk;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Flags are forced low outside DONE so reset and abort both leave them at 0.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = out_valid & ~carry_q;
  assign ovf       = out_valid & (a_q[WIDTH-1] ^ ~nb_q[WIDTH-1]) & (a_q[WIDTH-1] ^ diff_q[WIDTH-1]);
  assign zero      = out_valid & ~|diff_q;

endmodule

// File: tb/tb_seq_sub64.sv
// Self-checking bench for seq_sub64: directed corner cases, backpressure,
// mid-operation reset and randomized back-to-back traffic against a reference model.
module tb_seq_sub64;

  localparam int W    = 64;
  localparam int NCYC = 8;
  localparam logic signed [65:0] SMAX = 66'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] SMIN = -66'sh8000_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout, ovf, zero;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_sub64 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  // Reference: plain wide arithmetic, unsigned for diff/borrow, signed for overflow.
  function automatic void model(input logic [63:0] ma, input logic [63:0] mb, input logic mbin,
                                output logic [63:0] md, output logic mbo, output logic mov,
                                output logic mz);
    logic [64:0] u;
    logic signed [65:0] sa, sb, r;
    u   = {1'b0, ma} - {1'b0, mb} - 65'(mbin);
    md  = u[63:0];
    mbo = ({1'b0, ma} < ({1'b0, mb} + 65'(mbin)));
    sa  = $signed({{2{ma[63]}}, ma});
    sb  = $signed({{2{mb[63]}}, mb});
    r   = sa - sb - $signed({65'd0, mbin});
    mov = (r > SMAX) || (r < SMIN);
    mz  = (md == 64'd0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one full transaction starting from IDLE; no checking here.
  task automatic run_op(input logic [63:0] oa, input logic [63:0] ob, input logic obin,
                        input int hold, input bit rnd_ready,
                        output logic [63:0] rd, output logic rbo, output logic rov,
                        output logic rz, output int lat, output int t_acc, output bit got);
    in_valid = 1'b1;
    a = oa;
    b = ob;
    bin = obin;
    tick();
    t_acc = cyc;
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      out_ready = rnd_ready ? 1'($urandom) : 1'b0;
      tick();
      lat++;
    end
    got = out_valid;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) tick();
    rd  = diff;
    rbo = bout;
    rov = ovf;
    rz  = zero;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    n_cmp++;
    if (diff !== '0 || bout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out: diff=%h bout=%b ovf=%b zero=%b required all 0", diff, bout, ovf, zero);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [63:0] va [7];
    logic [63:0] vb [7];
    logic        vc [7];
    logic [63:0] rd, md;
    logic rbo, rov, rz, mbo, mov, mz;
    int lat, t;
    bit got;
    va = '{64'd5, 64'd0, 64'h100, 64'h8000_0000_0000_0000, 64'h1234, 64'h1234, 64'd0};
    vb = '{64'd3, 64'd1, 64'd1, 64'd1, 64'h1234, 64'h1234, 64'h8000_0000_0000_0000};
    vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      run_op(va[i], vb[i], vc[i], 0, 1'b0, rd, rbo, rov, rz, lat, t, got);
      model(va[i], vb[i], vc[i], md, mbo, mov, mz);
      n_cmp++;
      if (!got || lat != NCYC) begin
        n_err++;
        $display("FAIL dir_latency[%0d]: got=%0d lat=%0d required %0d", i, got, lat, NCYC);
      end
      n_cmp++;
      if (rd !== md || rbo !== mbo || rov !== mov || rz !== mz) begin
        n_err++;
        $display("FAIL dir_result[%0d]: diff=%h bout=%b ovf=%b zero=%b required %h %b %b %b",
                 i, rd, rbo, rov, rz, md, mbo, mov, mz);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a2, b2, md, rd, hd;
    logic mbo, mov, mz, rbo, rov, rz, hbo, hov, hz;
    int lat, t, k;
    bit got;
    a2 = 64'hDEAD_BEEF_0000_1111;
    b2 = 64'h0123_4567_89AB_CDEF;
    in_valid = 1'b1;
    a = 64'd5;
    b = 64'd3;
    bin = 1'b0;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    n_cmp++;
    if (!out_valid) begin
      n_err++;
      $display("FAIL bp_done: out_valid=%b required 1", out_valid);
    end
    hd = diff;
    hbo = bout;
    hov = ovf;
    hz = zero;
    in_valid = 1'b1;
    a = a2;
    b = b2;
    bin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (diff !== 64'd2 || diff !== hd || bout !== hbo || ovf !== hov || zero !== hz ||
          bout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: diff=%h bout=%b ovf=%b zero=%b in_ready=%b out_valid=%b required 2 0 0 0 0 1",
                 i, diff, bout, ovf, zero, in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    run_op(a2, b2, 1'b1, 0, 1'b0, rd, rbo, rov, rz, lat, t, got);
    model(a2, b2, 1'b1, md, mbo, mov, mz);
    n_cmp++;
    if (!got || rd !== md || rbo !== mbo || rov !== mov || rz !== mz) begin
      n_err++;
      $display("FAIL bp_next: diff=%h bout=%b ovf=%b zero=%b required %h %b %b %b",
               rd, rbo, rov, rz, md, mbo, mov, mz);
    end
  endtask

  task automatic test_reset_midop();
    logic [63:0] rd;
    logic rbo, rov, rz;
    int lat, t;
    bit got;
    in_valid = 1'b1;
    a = 64'hFFFF_0000_FFFF_0000;
    b = 64'h1;
    bin = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== '0 || bout !== 1'b0) begin
      n_err++;
      $display("FAIL midop_reset: out_valid=%b in_ready=%b diff=%h bout=%b required 0 1 0 0",
               out_valid, in_ready, diff, bout);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_op(64'd10, 64'd4, 1'b0, 0, 1'b0, rd, rbo, rov, rz, lat, t, got);
    n_cmp++;
    if (!got || rd !== 64'd6 || rbo !== 1'b0 || lat != NCYC) begin
      n_err++;
      $display("FAIL midop_after: diff=%h bout=%b lat=%0d required 6 0 %0d", rd, rbo, lat, NCYC);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd;
    logic rbo, rov, rz;
    int lat, t1, t2;
    bit got;
    run_op(64'd100, 64'd1, 1'b0, 0, 1'b0, rd, rbo, rov, rz, lat, t1, got);
    run_op(64'd7, 64'd9, 1'b1, 0, 1'b0, rd, rbo, rov, rz, lat, t2, got);
    n_cmp++;
    if (t2 - t1 != NCYC + 2) begin
      n_err++;
      $display("FAIL b2b_period: %0d cycles required %0d", t2 - t1, NCYC + 2);
    end
    n_cmp++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FFFD || rbo !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_result: diff=%h bout=%b required fffffffffffffffd 1", rd, rbo);
    end
  endtask

  task automatic test_random();
    logic [63:0] ra, rb, rd, md;
    logic rc, rbo, rov, rz, mbo, mov, mz;
    int lat, t;
    bit got;
    for (int i = 0; i < 200; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: ra = {32'd0, ra[31:0]};
        2: rb = {1'b1, rb[62:0]};
        3: ra = {1'b0, 63'h7FFF_FFFF_FFFF_FFFF};
        default: ;
      endcase
      run_op(ra, rb, rc, $urandom_range(0, 3), 1'b1, rd, rbo, rov, rz, lat, t, got);
      model(ra, rb, rc, md, mbo, mov, mz);
      n_cmp++;
      if (!got || lat != NCYC || rd !== md || rbo !== mbo || rov !== mov || rz !== mz) begin
        n_err++;
        $display("FAIL rand[%0d]: a=%h b=%h bin=%b diff=%h bout=%b ovf=%b zero=%b lat=%0d required %h %b %b %b %0d",
                 i, ra, rb, rc, rd, rbo, rov, rz, lat, md, mbo, mov, mz, NCYC);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
